// File: rtl/sp_mul_share_arb_if.sv
// Requester and result handshake bundle for the shared 12x14 multiplier arbiter.
// The master side is the requester/consumer environment, the slave side is the arbiter.
interface sp_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [12*NUM_REQ-1:0] req_a;
    logic [14*NUM_REQ-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [25:0]           res_data;
    logic [ID_W-1:0]       res_id;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/sp_mul_share_arb.sv
// Round-robin arbiter time-sharing one unsigned 12x14 multiplier among NUM_REQ requesters,
// with a one-entry result register that passes through when the consumer drains it.
module sp_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    sp_mul_share_arb_if.slave bus
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [ID_W-1:0]    win_idx;
    logic               found;
    logic               accept;
    logic               hs;
    logic [NUM_REQ-1:0] ready;
    logic [11:0]        a_sel;
    logic [13:0]        b_sel;
    logic [25:0]        product;
    logic               res_valid_q;
    logic [25:0]        res_data_q;
    logic [ID_W-1:0]    res_id_q;

    // Search starts at the pointer and wraps, so the first valid index after the last winner wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found   = 1'b1;
                win_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign accept = !res_valid_q || bus.res_ready;
    // Gating with reset keeps req_ready silent while the block is held in reset.
    assign hs     = found && accept && ap_rst_n;

    always_comb begin
        ready = '0;
        if (hs) begin
            ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = win_idx + ID_W'(1);
        if (int'(win_idx) == NUM_REQ - 1) begin
            rr_ptr_next = '0;
        end
    end

    assign a_sel   = bus.req_a[int'(win_idx)*12 +: 12];
    assign b_sel   = bus.req_b[int'(win_idx)*14 +: 14];
    assign product = 26'(a_sel) * 26'(b_sel);

    // A new product overwrites the register even while draining, so back-to-back results have no bubble.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else if (hs) begin
            rr_ptr      <= rr_ptr_next;
            res_valid_q <= 1'b1;
            res_data_q  <= product;
            res_id_q    <= win_idx;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.busy      = res_valid_q || (|bus.req_valid);

endmodule

// File: doc/sp_mul_share_arb.md
# sp_mul_share_arb

Round-robin arbiter and sequencer that time-shares one unsigned 12x14 -> 26-bit multiplier among NUM_REQ requesters in the EMTF sector-processor datapath. Each requester presents operands over a valid/ready handshake. The arbiter grants one requester per cycle, registers the product with the winner's ID, and returns it over a single valid/ready result channel. Peak throughput is one multiply per cycle.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)), minimum 1
- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  bit i: requester i holds a valid operand pair
- req_a  in  12*NUM_REQ  unsigned operand a; requester i at bits [12i+11:12i]
- req_b  in  14*NUM_REQ  unsigned operand b; requester i at bits [14i+13:14i]
- req_ready  out  NUM_REQ  bit i: requester i accepted this cycle; one-hot or zero
- res_valid  out  1  result register holds an undelivered product
- res_ready  in  1  downstream accepts the result this cycle
- res_data  out  26  product a*b, unsigned, full width, no truncation
- res_id  out  ID_W  index of the requester that produced res_data
- busy  out  1  res_valid OR any req_valid bit set

## Operation
- Shared resource: one multiplier instance, whose inputs are muxed from the granted requester. The product is `$unsigned(a)*$unsigned(b)` at 26 bits. The maximum product, 4095*16383 = 67,088,385, fits, so there is no overflow handling.
- accept = !res_valid || res_ready. This is a one-entry output register with pass-through on drain.
- Grant selection is combinational round-robin. Starting from pointer rr_ptr, the first i in order rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ, with req_valid[i]=1 wins.
- req_ready[i] = accept && (i is the winner). No winner means req_ready is all zeros.
- Handshake on req_valid[i] && req_ready[i]:
  - res_data <= a_i*b_i, res_id <= i, res_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- On res_valid && res_ready with no new handshake: res_valid <= 0. res_data and res_id hold their last values.
- No handshake: rr_ptr unchanged.
- Requester rules, which the verifier checks with an assertion:
  - Once req_valid[i] is raised, it stays high with req_a/req_b stable until req_ready[i].
  - The arbiter never drops a request and never grants an invalid one.
- Stall: while res_valid=1 and res_ready=0, res_data and res_id hold stable and req_ready is all zeros.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepted transactions.
- State: rr_ptr (ID_W bits), res_valid, res_data, res_id. There is no other FSM.

## Timing
- Reset (asynchronous assert, synchronous release): res_valid=0, res_data=0, res_id=0, rr_ptr=0, req_ready=0 (all zeros), busy follows its inputs.
- Latency: a handshake in cycle N gives res_valid=1 with the product in cycle N+1.
- Back-to-back: with res_ready held at 1, one result per cycle. Requesters are served in rotating order.
- Simultaneous drain and accept in the same cycle: the new product replaces the old one and res_valid stays 1, with no bubble.
- Reset mid-operation: an in-flight result is discarded and no req_ready pulse occurs during reset. After release, arbitration restarts at requester 0.
- Combinational paths:
  - req_valid and res_ready to req_ready.
  - req_a/req_b to the multiplier to the res_data register.
  - There is no combinational path from requester inputs to res_*.

## Test plan
- Reset: hold ap_rst_n=0 with req_valid=4'b1111 -> req_ready=0, res_valid=0, res_data=0, res_id=0. Then release.
- Single request: req 2 with a=4095, b=16383, res_ready=1.
  - req_ready=4'b0100 in cycle N.
  - Cycle N+1: res_valid=1, res_data=67,088,385, res_id=2.
- Round robin: all four requesters valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0,1 with no idle cycles.
  - Products check per requester, e.g. a=i+1, b=100*(i+1) gives 100, 400, 900, 1600.
- Backpressure: with res_valid=1, hold res_ready=0 for 5 cycles while req 1 and req 3 are valid.
  - req_ready stays 0 and res_data/res_id stay stable.
  - When res_ready rises, the next grant goes to the requester after the last winner, and the new result appears the next cycle with no loss.
- Sparse and wrap: request only req 3, then only req 0 -> grants 3 then 0. rr_ptr wraps to 0 after 3, then becomes 1.
- Reset mid-stall: set res_valid=1, res_ready=0, then pulse ap_rst_n low for one cycle -> res_valid=0 immediately (asynchronous). The first grant after release goes to the lowest valid index.
